reset_sequencer: RTL



---
 rtl/reset_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - merges synchronised reset requests, stretches them and releases domains in a staggered order
// Also keeps sticky reset causes and a saturating reset-event count for slow-control readout.
module reset_sequencer #(
    parameter int N_SRC       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int N_DOM       = 3,
    parameter int STAGGER     = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             por_i,
    input  logic [N_SRC-1:0] src_req_i,
    input  logic [N_SRC-1:0] src_mask_i,
    input  logic             status_clr_i,
    output logic [N_DOM-1:0] rst_dom_o,
    output logic             ready_o,
    output logic [N_SRC:0]   cause_o,
    output logic [CNT_W-1:0] rst_count_o
);
    localparam int HW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [HW-1:0] HOLD_INIT  = HW'(STRETCH - 1);
    localparam logic [SW-1:0] STAG_INIT  = SW'(STAGGER - 1);
    localparam logic [IW-1:0] LAST_DOM   = IW'(N_DOM - 1);

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

    // Element 0 is the newest sample; masking happens before the first flop.
    logic [SYNC_STAGES-1:0][N_SRC:0] r_sync;
    logic [N_SRC:0]                  w_req_sync;
    logic                            w_any_req;

    state_t           r_state, w_state_n;
    logic [HW-1:0]    r_hold, w_hold_n;
    logic [SW-1:0]    r_stag, w_stag_n;
    logic [IW-1:0]    r_idx, w_idx_n;
    logic [N_DOM-1:0] r_dom, w_dom_n;
    logic             r_ready, w_ready_n;
    logic [N_SRC:0]   r_cause, w_cause_n;
    logic [CNT_W-1:0] r_count, w_count_n;
    logic             w_incr;

    assign w_req_sync = r_sync[SYNC_STAGES-1];
    assign w_any_req  = |w_req_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= S_HOLD;
            r_hold  <= HOLD_INIT;
            r_stag  <= '0;
            r_idx   <= '0;
            r_dom   <= '1;
            r_ready <= 1'b0;
            r_cause <= '0;
            r_count <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], {por_i, src_req_i & src_mask_i}};
            r_state <= w_state_n;
            r_hold  <= w_hold_n;
            r_stag  <= w_stag_n;
            r_idx   <= w_idx_n;
            r_dom   <= w_dom_n;
            r_ready <= w_ready_n;
            r_cause <= w_cause_n;
            r_count <= w_count_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_hold_n  = r_hold;
        w_stag_n  = r_stag;
        w_idx_n   = r_idx;
        w_dom_n   = r_dom;
        w_ready_n = r_ready;
        w_incr    = 1'b0;
        case (r_state)
            S_HOLD: begin
                w_dom_n   = '1;
                w_ready_n = 1'b0;
                if (w_any_req) begin
                    w_hold_n = HOLD_INIT;
                end else if (r_hold != '0) begin
                    w_hold_n = r_hold - 1'b1;
                end else begin
                    w_dom_n[0] = 1'b0;
                    if (N_DOM == 1) begin
                        w_state_n = S_RUN;
                        w_ready_n = 1'b1;
                    end else begin
                        w_state_n = S_RELEASE;
                        w_stag_n  = STAG_INIT;
                        w_idx_n   = IW'(1);
                    end
                end
            end
            S_RELEASE: begin
                if (r_stag != '0) begin
                    w_stag_n = r_stag - 1'b1;
                end else begin
                    w_dom_n[r_idx] = 1'b0;
                    w_stag_n       = STAG_INIT;
                    w_idx_n        = r_idx + 1'b1;
                    if (r_idx == LAST_DOM) begin
                        w_state_n = S_RUN;
                        w_ready_n = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // A request outside HOLD re-enters HOLD and is the only event that counts.
        if (r_state != S_HOLD && w_any_req) begin
            w_state_n = S_HOLD;
            w_dom_n   = '1;
            w_ready_n = 1'b0;
            w_hold_n  = HOLD_INIT;
            w_incr    = 1'b1;
        end
    end

    always_comb begin
        w_cause_n = status_clr_i ? w_req_sync : (r_cause | w_req_sync);
        w_count_n = r_count;
        if (status_clr_i)
            w_count_n = w_incr ? CNT_W'(1) : '0;
        else if (w_incr && r_count != '1)
            w_count_n = r_count + 1'b1;
    end

    assign rst_dom_o   = r_dom;
    assign ready_o     = r_ready;
    assign cause_o     = r_cause;
    assign rst_count_o = r_count;
endmodule
